// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - memory-controller request/response bus for the MEM stage
interface mem_stage_if #(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 32
);
    logic              mc_req;
    logic              mc_wr;
    logic [ADDR_W-1:0] mc_addr;
    logic [1:0]        mc_len;
    logic [REG_W-1:0]  mc_wdata;
    logic              mc_done;
    logic [REG_W-1:0]  mc_rdata;

    modport master (
        output mc_req,
        output mc_wr,
        output mc_addr,
        output mc_len,
        output mc_wdata,
        input  mc_done,
        input  mc_rdata
    );

    modport slave (
        input  mc_req,
        input  mc_wr,
        input  mc_addr,
        input  mc_len,
        input  mc_wdata,
        output mc_done,
        output mc_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I MEM stage: load/store initiator toward the memory controller, pass-through otherwise
// Optional alignment checking is compiled in with MEM_ALIGN_CHECK_EN (adds output mem_misalign).
module mem_stage #(
    parameter int OPT_W  = 6,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [OPT_W-1:0]  mem_inst,
    input  logic [4:0]        mem_rd,
    input  logic [REG_W-1:0]  mem_vd,
    input  logic              mem_w_enable,
    input  logic [ADDR_W-1:0] mem_memctrl_addr,
    mem_stage_if.master       mc,
    output logic              stall_req,
    output logic [4:0]        wb_rd,
    output logic [REG_W-1:0]  wb_vd,
    output logic              wb_w_enable
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              mem_misalign
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [OPT_W-1:0] OP_LB  = OPT_W'(8'h0B);
    localparam logic [OPT_W-1:0] OP_LH  = OPT_W'(8'h0C);
    localparam logic [OPT_W-1:0] OP_LW  = OPT_W'(8'h0D);
    localparam logic [OPT_W-1:0] OP_LBU = OPT_W'(8'h0E);
    localparam logic [OPT_W-1:0] OP_LHU = OPT_W'(8'h0F);
    localparam logic [OPT_W-1:0] OP_SB  = OPT_W'(8'h10);
    localparam logic [OPT_W-1:0] OP_SH  = OPT_W'(8'h11);
    localparam logic [OPT_W-1:0] OP_SW  = OPT_W'(8'h12);

    logic [1:0]        r_state;
    logic [REG_W-1:0]  r_result;
    logic              r_mc_req;
    logic              r_mc_wr;
    logic [ADDR_W-1:0] r_mc_addr;
    logic [1:0]        r_mc_len;
    logic [REG_W-1:0]  r_mc_wdata;

    logic              w_is_load;
    logic              w_is_store;
    logic              w_is_mem;
    logic              w_is_half;
    logic              w_is_word;
    logic [1:0]        w_len;
    logic [REG_W-1:0]  w_ext;
    logic              w_misalign;
    logic              w_issue;

    assign mc.mc_req   = r_mc_req;
    assign mc.mc_wr    = r_mc_wr;
    assign mc.mc_addr  = r_mc_addr;
    assign mc.mc_len   = r_mc_len;
    assign mc.mc_wdata = r_mc_wdata;

    // Opcode decode; EX/MEM is stalled while an access is in flight, so mem_inst stays valid through DONE.
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_is_half  = 1'b0;
        w_is_word  = 1'b0;
        w_len      = 2'd0;
        case (mem_inst)
            OP_LB, OP_LBU: begin
                w_is_load = 1'b1;
                w_len     = 2'd0;
            end
            OP_LH, OP_LHU: begin
                w_is_load = 1'b1;
                w_is_half = 1'b1;
                w_len     = 2'd1;
            end
            OP_LW: begin
                w_is_load = 1'b1;
                w_is_word = 1'b1;
                w_len     = 2'd3;
            end
            OP_SB: begin
                w_is_store = 1'b1;
                w_len      = 2'd0;
            end
            OP_SH: begin
                w_is_store = 1'b1;
                w_is_half  = 1'b1;
                w_len      = 2'd1;
            end
            OP_SW: begin
                w_is_store = 1'b1;
                w_is_word  = 1'b1;
                w_len      = 2'd3;
            end
            default: begin
                w_is_load  = 1'b0;
                w_is_store = 1'b0;
            end
        endcase
    end

    assign w_is_mem = w_is_load | w_is_store;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = (w_is_half & mem_memctrl_addr[0]) |
                        (w_is_word & (mem_memctrl_addr[1:0] != 2'b00));
    assign mem_misalign = rst && (r_state == S_IDLE) && w_is_mem && w_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    assign w_issue = w_is_mem & ~w_misalign;

    always_comb begin
        w_ext = mc.mc_rdata;
        case (mem_inst)
            OP_LB:   w_ext = {{(REG_W-8){mc.mc_rdata[7]}}, mc.mc_rdata[7:0]};
            OP_LBU:  w_ext = {{(REG_W-8){1'b0}}, mc.mc_rdata[7:0]};
            OP_LH:   w_ext = {{(REG_W-16){mc.mc_rdata[15]}}, mc.mc_rdata[15:0]};
            OP_LHU:  w_ext = {{(REG_W-16){1'b0}}, mc.mc_rdata[15:0]};
            default: w_ext = mc.mc_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_result   <= '0;
            r_mc_req   <= 1'b0;
            r_mc_wr    <= 1'b0;
            r_mc_addr  <= '0;
            r_mc_len   <= 2'd0;
            r_mc_wdata <= '0;
        end else if (rdy) begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_mc_req   <= 1'b1;
                        r_mc_wr    <= w_is_store;
                        r_mc_addr  <= mem_memctrl_addr;
                        r_mc_len   <= w_len;
                        r_mc_wdata <= mem_vd;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mc.mc_done) begin
                        r_mc_req <= 1'b0;
                        if (w_is_load) begin
                            r_result <= w_ext;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Dropping stall_req in DONE lets EX/MEM advance on the same edge that returns us to IDLE.
    always_comb begin
        stall_req   = 1'b0;
        wb_rd       = 5'd0;
        wb_vd       = '0;
        wb_w_enable = 1'b0;
        if (rst) begin
            wb_rd = mem_rd;
            wb_vd = mem_vd;
            case (r_state)
                S_IDLE: begin
                    if (w_is_mem) begin
                        stall_req   = ~w_misalign;
                        wb_w_enable = 1'b0;
                    end else begin
                        wb_w_enable = mem_w_enable;
                    end
                end
                S_BUSY: begin
                    stall_req   = 1'b1;
                    wb_w_enable = 1'b0;
                end
                S_DONE: begin
                    if (w_is_load) begin
                        wb_vd       = r_result;
                        wb_w_enable = mem_w_enable;
                    end else begin
                        wb_w_enable = 1'b0;
                    end
                end
                default: begin
                    wb_w_enable = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard testbench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [5:0]  mem_inst;
    logic [4:0]  mem_rd;
    logic [31:0] mem_vd;
    logic        mem_w_enable;
    logic [31:0] mem_memctrl_addr;
    logic        stall_req;
    logic [4:0]  wb_rd;
    logic [31:0] wb_vd;
    logic        wb_w_enable;
`ifdef MEM_ALIGN_CHECK_EN
    logic        mem_misalign;
`endif

    always #5 clk = ~clk;

    mem_stage_if #(.ADDR_W(32), .REG_W(32)) mc_bus ();

    mem_stage #(.OPT_W(6), .ADDR_W(32), .REG_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .mem_inst         (mem_inst),
        .mem_rd           (mem_rd),
        .mem_vd           (mem_vd),
        .mem_w_enable     (mem_w_enable),
        .mem_memctrl_addr (mem_memctrl_addr),
        .mc               (mc_bus),
        .stall_req        (stall_req),
        .wb_rd            (wb_rd),
        .wb_vd            (wb_vd),
        .wb_w_enable      (wb_w_enable)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .mem_misalign     (mem_misalign)
`endif
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] vd;
        logic        we;
    } wb_t;

    wb_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic pop_check(input string tag);
        wb_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_stall"}, 32'(stall_req), 32'd0);
            check({tag, "_rd"}, 32'(wb_rd), 32'(e.rd));
            check({tag, "_we"}, 32'(wb_w_enable), 32'(e.we));
            if (e.we) check({tag, "_vd"}, wb_vd, e.vd);
        end
    endtask

    task automatic drive(input logic [5:0] inst, input logic [4:0] rd, input logic [31:0] vd,
                         input logic we, input logic [31:0] addr);
        mem_inst         = inst;
        mem_rd           = rd;
        mem_vd           = vd;
        mem_w_enable     = we;
        mem_memctrl_addr = addr;
    endtask

    // Called right after an active edge; leaves the bench just after the following edge.
    task automatic nonmem(input string tag, input logic [5:0] inst, input logic [4:0] rd,
                          input logic [31:0] vd, input logic we);
        drive(inst, rd, vd, we, 32'h0);
        sb.push_back('{rd: rd, vd: vd, we: we});
        sample();
        pop_check(tag);
        tick();
    endtask

    task automatic memop(input string tag, input logic [5:0] inst, input logic [4:0] rd,
                         input logic [31:0] vd, input logic [31:0] addr, input logic [31:0] rdata,
                         input int busy, input int frz, input logic [31:0] exp_vd,
                         input logic exp_we, input logic exp_wr, input logic [1:0] exp_len);
        drive(inst, rd, vd, 1'b1, addr);
        sb.push_back('{rd: rd, vd: exp_vd, we: exp_we});
        sample();
        check({tag, "_idle_stall"}, 32'(stall_req), 32'd1);
        check({tag, "_idle_we"}, 32'(wb_w_enable), 32'd0);
        tick();
        sample();
        check({tag, "_req"}, 32'(mc_bus.mc_req), 32'd1);
        check({tag, "_wr"}, 32'(mc_bus.mc_wr), 32'(exp_wr));
        check({tag, "_len"}, 32'(mc_bus.mc_len), 32'(exp_len));
        check({tag, "_addr"}, mc_bus.mc_addr, addr);
        if (exp_wr) check({tag, "_wdata"}, mc_bus.mc_wdata, vd);
        check({tag, "_busy_stall"}, 32'(stall_req), 32'd1);
        if (frz > 0) begin
            rdy = 1'b0;
            for (int i = 0; i < frz; i++) begin
                tick();
                sample();
                check({tag, "_frz_req"}, 32'(mc_bus.mc_req), 32'd1);
                check({tag, "_frz_addr"}, mc_bus.mc_addr, addr);
                check({tag, "_frz_len"}, 32'(mc_bus.mc_len), 32'(exp_len));
                check({tag, "_frz_stall"}, 32'(stall_req), 32'd1);
            end
            rdy = 1'b1;
        end
        for (int i = 1; i < busy; i++) begin
            tick();
            sample();
            check({tag, "_busy_stall"}, 32'(stall_req), 32'd1);
        end
        mc_bus.mc_done  = 1'b1;
        mc_bus.mc_rdata = rdata;
        tick();
        mc_bus.mc_done  = 1'b0;
        mc_bus.mc_rdata = 32'hA5A5_A5A5;
        sample();
        pop_check({tag, "_done"});
        check({tag, "_done_req"}, 32'(mc_bus.mc_req), 32'd0);
        tick();
        drive(6'h00, 5'd0, 32'h0, 1'b0, 32'h0);
        sample();
        check({tag, "_back_idle_stall"}, 32'(stall_req), 32'd0);
        check({tag, "_back_idle_req"}, 32'(mc_bus.mc_req), 32'd0);
        tick();
    endtask

    initial begin
        rst             = 1'b0;
        rdy             = 1'b1;
        mc_bus.mc_done  = 1'b0;
        mc_bus.mc_rdata = 32'h0;
        drive(6'h0D, 5'd7, 32'h1111_2222, 1'b1, 32'h400);

        // Reset: outputs must be zero even while a load is presented.
        tick();
        tick();
        sample();
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("rst_wb_vd", wb_vd, 32'd0);
        check("rst_wb_we", 32'(wb_w_enable), 32'd0);
        check("rst_mc_req", 32'(mc_bus.mc_req), 32'd0);
        check("rst_mc_addr", mc_bus.mc_addr, 32'd0);
        check("rst_mc_wdata", mc_bus.mc_wdata, 32'd0);
        rst = 1'b1;
        drive(6'h01, 5'd5, 32'h1234, 1'b1, 32'h0);
        #1;

        nonmem("add", 6'h01, 5'd5, 32'h0000_1234, 1'b1);
        nonmem("nowe", 6'h02, 5'd9, 32'hCAFE_0001, 1'b0);

        memop("lb",  6'h0B, 5'd3, 32'h0, 32'h100, 32'h0000_00F0, 2, 0, 32'hFFFF_FFF0, 1'b1, 1'b0, 2'd0);
        memop("lbu", 6'h0E, 5'd4, 32'h0, 32'h100, 32'h0000_00F0, 2, 0, 32'h0000_00F0, 1'b1, 1'b0, 2'd0);
        memop("lh",  6'h0C, 5'd6, 32'h0, 32'h204, 32'h1234_8001, 1, 0, 32'hFFFF_8001, 1'b1, 1'b0, 2'd1);
        memop("lhu", 6'h0F, 5'd8, 32'h0, 32'h206, 32'h1234_8001, 1, 0, 32'h0000_8001, 1'b1, 1'b0, 2'd1);
        memop("sh",  6'h11, 5'd2, 32'hDEAD_BEEF, 32'h202, 32'h0, 2, 0, 32'h0, 1'b0, 1'b1, 2'd1);
        memop("sb",  6'h10, 5'd1, 32'h0000_0077, 32'h301, 32'h0, 1, 0, 32'h0, 1'b0, 1'b1, 2'd0);
        memop("lwfrz", 6'h0D, 5'd10, 32'h0, 32'h500, 32'h89AB_CDEF, 1, 4, 32'h89AB_CDEF, 1'b1, 1'b0, 2'd3);
        memop("sw",  6'h12, 5'd11, 32'h0BAD_F00D, 32'h600, 32'h0, 3, 0, 32'h0, 1'b0, 1'b1, 2'd3);

        // Reset during BUSY, then a stale mc_done must be ignored.
        drive(6'h0D, 5'd12, 32'h0, 1'b1, 32'h700);
        tick();
        sample();
        check("rmid_req_before", 32'(mc_bus.mc_req), 32'd1);
        rst = 1'b0;
        drive(6'h00, 5'd0, 32'h0, 1'b0, 32'h0);
        tick();
        sample();
        check("rmid_req", 32'(mc_bus.mc_req), 32'd0);
        check("rmid_stall", 32'(stall_req), 32'd0);
        rst = 1'b1;
        mc_bus.mc_done  = 1'b1;
        mc_bus.mc_rdata = 32'h5555_5555;
        tick();
        mc_bus.mc_done = 1'b0;
        sample();
        check("rmid_late_req", 32'(mc_bus.mc_req), 32'd0);
        check("rmid_late_stall", 32'(stall_req), 32'd0);
        check("rmid_late_we", 32'(wb_w_enable), 32'd0);
        tick();
        nonmem("post_rst_add", 6'h01, 5'd13, 32'h0000_ABCD, 1'b1);

`ifdef MEM_ALIGN_CHECK_EN
        drive(6'h0D, 5'd14, 32'h0, 1'b1, 32'h102);
        sample();
        check("mis_flag", 32'(mem_misalign), 32'd1);
        check("mis_stall", 32'(stall_req), 32'd0);
        check("mis_we", 32'(wb_w_enable), 32'd0);
        tick();
        sample();
        check("mis_req", 32'(mc_bus.mc_req), 32'd0);
        check("mis_flag_hold", 32'(mem_misalign), 32'd1);
        drive(6'h00, 5'd0, 32'h0, 1'b0, 32'h0);
        tick();
        memop("lw_al", 6'h0D, 5'd15, 32'h0, 32'h104, 32'h0102_0304, 1, 0, 32'h0102_0304, 1'b1, 1'b0, 2'd3);
`else
        memop("lw_unal", 6'h0D, 5'd14, 32'h0, 32'h102, 32'h0102_0304, 1, 0, 32'h0102_0304, 1'b1, 1'b0, 2'd3);
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the 5-stage RV32I core. It consumes the EX/MEM pipeline register outputs (inst, rd, vd, w_enable, memctrl_addr).
- For loads and stores it acts as the initiator toward the memory controller. For all other ops it passes results through to the MEM/WB register.
- Holds the pipeline through stall_req until the memory access completes. Load data is sign- or zero-extended before writeback.

Parameters:
- OPT_W, 6, width of the internal opcode bus
- ADDR_W, 32, address width
- REG_W, 32, data and register width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-low reset
- rdy  in  1  global ready; low = freeze all state
- mem_inst  in  OPT_W  opcode from EX/MEM
- mem_rd  in  5  destination register
- mem_vd  in  REG_W  ALU result, or store data for stores
- mem_w_enable  in  1  register write enable
- mem_memctrl_addr  in  ADDR_W  effective address
- mc_req  out  1  memory request, held until done
- mc_wr  out  1  1 = store, 0 = load
- mc_addr  out  ADDR_W  request address
- mc_len  out  2  access bytes minus 1 (0 = byte, 1 = half, 3 = word)
- mc_wdata  out  REG_W  store data, right-aligned
- mc_done  in  1  one-cycle completion pulse
- mc_rdata  in  REG_W  load data, right-aligned, valid with mc_done
- stall_req  out  1  request pipeline hold; drives bit 3 of the stall controller
- wb_rd  out  5  to MEM/WB
- wb_vd  out  REG_W  to MEM/WB
- wb_w_enable  out  1  to MEM/WB

Behaviour:
- Opcode map: LB=0x0B, LH=0x0C, LW=0x0D, LBU=0x0E, LHU=0x0F, SB=0x10, SH=0x11, SW=0x12. Any other value is a non-memory op.
- FSM states: IDLE, BUSY, DONE. Registers: state, mc_* outputs, result[REG_W].
- All registers update only on a rising clk edge with rdy=1. While rst=0 they reset regardless of rdy.

Reset (rst=0 at the clock edge):
- state=IDLE, result=0.
- mc_req=0, mc_wr=0, mc_addr=0, mc_len=0, mc_wdata=0.
- Combinational outputs are forced to 0 while rst=0: stall_req, wb_rd, wb_vd, wb_w_enable.
- Reset mid-access drops mc_req on the next edge. Any later mc_done is ignored.

IDLE:
- Non-memory op: wb_* = mem_* combinationally; stall_req=0; zero-cycle latency.
- Memory op: stall_req=1 and wb_w_enable=0 (bubble). On the next edge: mc_req<=1, mc_wr, mc_addr<=mem_memctrl_addr, mc_len from the opcode, mc_wdata<=mem_vd. Go to BUSY.

BUSY:
- stall_req=1, wb_w_enable=0, mc_* held stable.
- On mc_done=1: mc_req<=0 and go to DONE.
- On mc_done for a load, result takes the extended mc_rdata:
  - LB: sign-extend [7:0]; LBU: zero-extend [7:0].
  - LH: sign-extend [15:0]; LHU: zero-extend [15:0].
  - LW: [31:0].
- On mc_done for a store, result is unchanged.

DONE:
- stall_req=0, so EX/MEM advances on this edge. wb_rd=mem_rd.
- Load: wb_vd=result, wb_w_enable=mem_w_enable.
- Store: wb_w_enable=0.
- Next edge goes to IDLE unconditionally. The new op is evaluated in IDLE; a back-to-back memory op costs one IDLE cycle.
- Minimum memory-op latency is 3 cycles: issue, done in the next cycle, DONE.

Boundary rules:
- mc_done outside BUSY is ignored.
- The memory controller shares rdy and never pulses mc_done while rdy=0.
- rdy=0: state and mc_* frozen; combinational outputs still follow the current state and inputs.
- No alignment checks unless the optional feature is compiled in; the memory controller handles unaligned bytes.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- When defined: adds output mem_misalign (1 bit).
  - A halfword op with addr[0]=1 or a word op with addr[1:0]≠0 is not issued.
  - That cycle in IDLE: stall_req=0, wb_w_enable=0, mem_misalign=1 (combinational, 0 under reset).
  - The FSM stays in IDLE.
- When undefined: the port is absent and all addresses are issued as-is.

Test Plan:
- Reset sequence: rst=0 for 2 cycles, then 1 → all outputs 0, state IDLE. Then present ADD with rd=5, vd=0x1234, w_enable=1 → same cycle wb_rd=5, wb_vd=0x1234, wb_w_enable=1, stall_req=0.
- LB at addr 0x100; mc_done after 2 BUSY cycles with rdata=0x000000F0 → mc_req=1, mc_len=0, mc_wr=0. stall_req high for 3 cycles; in DONE wb_vd=0xFFFFFFF0. Repeat as LBU → 0x000000F0.
- SH at addr 0x202, vd=0xDEADBEEF → mc_wr=1, mc_len=1, mc_wdata=0xDEADBEEF. In DONE wb_w_enable=0; then back to IDLE.
- Freeze: LW, then rdy=0 for 4 cycles while in BUSY → mc_* and state unchanged. After rdy=1, mc_done with 0x89ABCDEF → wb_vd=0x89ABCDEF.
- Reset mid-op: rst=0 while in BUSY, then mc_done pulse after rst=1 → mc_req=0, state IDLE, wb_w_enable=0, done ignored.
- With MEM_ALIGN_CHECK_EN: LW at 0x102 → mem_misalign=1, mc_req stays 0, stall_req=0, wb_w_enable=0.
